// File: rtl/vpbf_pkg.sv
// ---------------------------------------------------------------------------
// vpbf_pkg
// Shared definitions for the variable-precision BFloat16 datapath adders.
//   CPA_DEFAULT_WIDTH : default carry-propagate adder width (exponent/mantissa)
//   cpa_seg_width()   : bits per pipeline segment, ceil(width/stages)
//   clamp_approx()    : limits a requested approximate-LSB count to the width
// ---------------------------------------------------------------------------
package vpbf_pkg;

  localparam int CPA_DEFAULT_WIDTH = 11;

  function automatic int cpa_seg_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int clamp_approx(input int approx, input int width);
    return (approx > width) ? width : approx;
  endfunction

endpackage

// File: rtl/pipelined_var_cpa_if.sv
// ---------------------------------------------------------------------------
// pipelined_var_cpa_if
// Valid/ready bundle for the pipelined variable-precision adder.
//   Input side : in_valid, in_ready, in1, in2, cin, approx_bits
//   Output side: out_valid, out_ready, sum, cout
//   master     : the producer/consumer surrounding the adder
//   slave      : the adder itself
// ---------------------------------------------------------------------------
interface pipelined_var_cpa_if
  import vpbf_pkg::*;
#(
  parameter int WIDTH = CPA_DEFAULT_WIDTH
);
  localparam int AW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic [AW-1:0]    approx_bits;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, in1, in2, cin, approx_bits, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, in1, in2, cin, approx_bits, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/pipelined_var_cpa_segment.sv
// ---------------------------------------------------------------------------
// cpa_segment
// Combinational SW-bit slice of the LOA / ripple adder.
//   i_a, i_b : operand bits of this slice
//   i_mask   : per-bit approximate flag (1 = bit lies below n)
//   i_cin    : carry into the lowest bit of the slice
//   o_sum    : slice sum bits
//   o_cout   : carry out of the highest bit of the slice
// A masked bit produces a|b and emits a&b as its carry. Only the carry of
// bit n-1 is ever consumed by an exact bit, because every lower masked bit
// feeds another masked bit that ignores its incoming carry.
// ---------------------------------------------------------------------------
module cpa_segment #(
  parameter int SW = 1
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic [SW-1:0] i_mask,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);

  logic [SW:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < SW; gi++) begin : g_bit
    assign o_sum[gi]  = i_mask[gi] ? (i_a[gi] | i_b[gi])
                                   : (i_a[gi] ^ i_b[gi] ^ w_c[gi]);
    assign w_c[gi+1]  = i_mask[gi] ? (i_a[gi] & i_b[gi])
                                   : ((i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi])));
  end

  assign o_cout = w_c[SW];

endmodule

// File: rtl/pipelined_var_cpa.sv
// ---------------------------------------------------------------------------
// pipelined_var_cpa
// Pipelined carry-propagate adder with a per-transaction lower-part OR
// region. The ripple chain is cut into STAGES segments of ceil(WIDTH/STAGES)
// bits; each segment is followed by a register stage.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes every stage
//   bus : slave side of pipelined_var_cpa_if (valid/ready in and out)
// Each stage register keeps: valid, the operand bits still to be added,
// the sum bits produced so far, the carry into the next segment and the
// clamped approximate count. Operand and count registers exist only while
// later segments still need them.
// ---------------------------------------------------------------------------
module pipelined_var_cpa
  import vpbf_pkg::*;
#(
  parameter int WIDTH  = CPA_DEFAULT_WIDTH,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  pipelined_var_cpa_if.slave bus
);

  localparam int AW  = $clog2(WIDTH + 1);
  localparam int SEG = cpa_seg_width(WIDTH, STAGES);
  localparam int L   = STAGES - 1;

  logic [AW-1:0] w_n_in;

  assign w_n_in = AW'(clamp_approx(int'(bus.approx_bits), WIDTH));

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO  = gi * SEG;
    localparam int HI  = (LO + SEG >= WIDTH) ? WIDTH : LO + SEG;
    localparam int REM = WIDTH - HI;

    logic          r_valid;
    logic [HI-1:0] r_sum;
    logic          r_carry;
    logic          w_load;
    logic          w_vin;
    logic [HI-1:0] w_sum_nxt;
    logic          w_carry_nxt;

    // A stage may load when it is empty or its content moves on this cycle.
    if (gi == L) begin : g_last
      assign w_load = bus.out_ready || !r_valid;
    end else begin : g_mid
      assign w_load = !r_valid || g_stage[gi+1].w_load;
    end

    if (gi == 0) begin : g_vin
      assign w_vin = bus.in_valid;
    end else begin : g_vin_p
      assign w_vin = g_stage[gi-1].r_valid;
    end

    if (LO < WIDTH) begin : g_seg
      localparam int SW = HI - LO;

      // Operand bits from this segment upward; the low SW bits are consumed here.
      logic [WIDTH-LO-1:0] w_op_a;
      logic [WIDTH-LO-1:0] w_op_b;
      logic [AW-1:0]       w_n;
      logic                w_cin;
      logic [SW-1:0]       w_mask;
      logic [SW-1:0]       w_seg_sum;

      if (gi == 0) begin : g_src
        assign w_op_a    = bus.in1;
        assign w_op_b    = bus.in2;
        assign w_n       = w_n_in;
        // With n > 0 bit 0 is masked, so cin never reaches the exact chain.
        assign w_cin     = bus.cin;
        assign w_sum_nxt = w_seg_sum;
      end else begin : g_src
        assign w_op_a    = g_stage[gi-1].g_seg.g_rem.r_a;
        assign w_op_b    = g_stage[gi-1].g_seg.g_rem.r_b;
        assign w_n       = g_stage[gi-1].g_seg.g_rem.r_n;
        assign w_cin     = g_stage[gi-1].r_carry;
        assign w_sum_nxt = {w_seg_sum, g_stage[gi-1].r_sum};
      end

      for (genvar bi = 0; bi < SW; bi++) begin : g_mask
        assign w_mask[bi] = (32'(LO + bi) < 32'(w_n));
      end

      cpa_segment #(
        .SW(SW)
      ) u_seg (
        .i_a    (w_op_a[SW-1:0]),
        .i_b    (w_op_b[SW-1:0]),
        .i_mask (w_mask),
        .i_cin  (w_cin),
        .o_sum  (w_seg_sum),
        .o_cout (w_carry_nxt)
      );

      if (REM > 0) begin : g_rem
        logic [REM-1:0] r_a;
        logic [REM-1:0] r_b;
        logic [AW-1:0]  r_n;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_n <= '0;
          end else if (w_load) begin
            r_a <= w_op_a[WIDTH-LO-1:SW];
            r_b <= w_op_b[WIDTH-LO-1:SW];
            r_n <= w_n;
          end
        end
      end
    end else begin : g_pass
      // Segment lies beyond WIDTH: forward the finished result unchanged.
      assign w_sum_nxt   = g_stage[gi-1].r_sum;
      assign w_carry_nxt = g_stage[gi-1].r_carry;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_sum   <= '0;
        r_carry <= 1'b0;
      end else if (w_load) begin
        r_valid <= w_vin;
        r_sum   <= w_sum_nxt;
        r_carry <= w_carry_nxt;
      end
    end
  end

  assign bus.in_ready  = g_stage[0].w_load && !rst;
  assign bus.out_valid = g_stage[L].r_valid;
  assign bus.sum       = g_stage[L].r_sum;
  assign bus.cout      = g_stage[L].r_carry;

endmodule

// File: tb/tb_pipelined_var_cpa.sv
// ---------------------------------------------------------------------------
// tb_pipelined_var_cpa
// Directed bench for pipelined_var_cpa (WIDTH=11, STAGES=2): reset state,
// exact and approximate sums, clamp, backpressure hold/drain, streaming
// against a bit-serial LOA model, and asynchronous reset mid-flight.
// ---------------------------------------------------------------------------
module tb_pipelined_var_cpa;

  localparam int WIDTH  = 11;
  localparam int STAGES = 2;
  localparam int AW     = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipelined_var_cpa_if #(.WIDTH(WIDTH)) bus ();

  pipelined_var_cpa #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Bit-serial reference: OR below n, carry a[n-1]&b[n-1] into bit n, ripple above.
  function automatic logic [WIDTH:0] loa(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic c, input int ab);
    int n;
    logic cy;
    logic [WIDTH-1:0] s;
    n = (ab > WIDTH) ? WIDTH : ab;
    s = '0;
    if (n == 0) cy = c;
    else        cy = a[n-1] & b[n-1];
    for (int i = 0; i < WIDTH; i++) begin
      if (i < n) begin
        s[i] = a[i] | b[i];
      end else begin
        s[i] = a[i] ^ b[i] ^ cy;
        cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
    end
    return {cy, s};
  endfunction

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic [AW-1:0] ab);
    bus.in_valid    = 1'b1;
    bus.in1         = a;
    bus.in2         = b;
    bus.cin         = c;
    bus.approx_bits = ab;
  endtask

  task automatic single(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [AW-1:0] ab,
                        input logic [WIDTH-1:0] es, input logic ec);
    @(negedge clk);
    drive(a, b, c, ab);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    $display("txn %s a=%03h b=%03h cin=%0d approx=%0d sum=%03h cout=%0d",
             tag, a, b, c, ab, bus.sum, bus.cout);
  endtask

  logic [WIDTH-1:0] sa [16];
  logic [WIDTH-1:0] sb [16];
  logic             sc [16];
  logic [AW-1:0]    sab [16];
  logic [WIDTH:0]   sexp [16];

  initial begin
    bus.in_valid    = 1'b0;
    bus.in1         = '0;
    bus.in2         = '0;
    bus.cin         = 1'b0;
    bus.approx_bits = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed single transactions
    single("exact_wrap",      11'h7FF, 11'h001, 1'b0, 4'd0,  11'h000, 1'b1);
    single("exact_wrap_cin",  11'h7FF, 11'h001, 1'b1, 4'd0,  11'h001, 1'b1);
    single("exact_boundary",  11'h03F, 11'h001, 1'b0, 4'd0,  11'h040, 1'b0);
    single("approx4_inject",  11'h008, 11'h008, 1'b0, 4'd4,  11'h018, 1'b0);
    single("approx4_cin_ign", 11'h00F, 11'h001, 1'b1, 4'd4,  11'h00F, 1'b0);
    single("clamp_full",      11'h400, 11'h401, 1'b0, 4'd15, 11'h401, 1'b1);

    // Backpressure: four transactions with sums 1..4 while out_ready is low
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(11'd1, 11'd0, 1'b0, 4'd0);
    chk("bp_t1_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(11'd2, 11'd0, 1'b0, 4'd0);
    chk("bp_t2_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_t2_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    drive(11'd3, 11'd0, 1'b0, 4'd0);
    chk("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
    chk("bp_head_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_sum", 32'(bus.sum), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_sum", 32'(bus.sum), 32'd1);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    $display("txn bp_drain sum=%0d", bus.sum);
    @(negedge clk);
    chk("bp_drain2_sum", 32'(bus.sum), 32'd2);
    chk("bp_drain2_valid", 32'(bus.out_valid), 32'd1);
    $display("txn bp_drain sum=%0d", bus.sum);
    drive(11'd4, 11'd0, 1'b0, 4'd0);
    chk("bp_t4_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_drain3_sum", 32'(bus.sum), 32'd3);
    chk("bp_drain3_valid", 32'(bus.out_valid), 32'd1);
    $display("txn bp_drain sum=%0d", bus.sum);
    @(negedge clk);
    chk("bp_drain4_sum", 32'(bus.sum), 32'd4);
    chk("bp_drain4_valid", 32'(bus.out_valid), 32'd1);
    $display("txn bp_drain sum=%0d", bus.sum);
    @(negedge clk);
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming: 16 back-to-back random transactions with random approx_bits
    for (int i = 0; i < 16; i++) begin
      sa[i]   = WIDTH'($urandom);
      sb[i]   = WIDTH'($urandom);
      sc[i]   = 1'($urandom);
      sab[i]  = AW'($urandom_range(0, 15));
      sexp[i] = loa(sa[i], sb[i], sc[i], int'(sab[i]));
    end
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_result", 32'({bus.cout, bus.sum}), 32'(sexp[j-2]));
        $display("txn stream %0d a=%03h b=%03h cin=%0d approx=%0d sum=%03h cout=%0d",
                 j - 2, sa[j-2], sb[j-2], sc[j-2], sab[j-2], bus.sum, bus.cout);
      end else begin
        chk("stream_latency", 32'(bus.out_valid), 32'd0);
      end
      if (j < 16) begin
        drive(sa[j], sb[j], sc[j], sab[j]);
        chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // Asynchronous reset with two transactions in flight
    @(negedge clk);
    drive(11'h7FF, 11'h7FF, 1'b0, 4'd0);
    @(negedge clk);
    drive(11'h123, 11'h001, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("rstmf_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("rstmf_pre_sum", 32'(bus.sum), 32'h7FE);
    chk("rstmf_pre_cout", 32'(bus.cout), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmf_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmf_sum", 32'(bus.sum), 32'd0);
    chk("rstmf_cout", 32'(bus.cout), 32'd0);
    chk("rstmf_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmf_no_stale", 32'(bus.out_valid), 32'd0);
    end
    single("after_rst", 11'h100, 11'h0FF, 1'b1, 4'd0, 11'h200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
